// File: rtl/idct2_mac_round_clip.sv
`default_nettype none
// ============================================================================
//  Module   : idct2_mac_round_clip
//  Purpose  : Accumulates TAPS signed IDCT2 coefficient products per output
//             sample. It adds the rounding offset, arithmetic-shifts right by a
//             runtime amount and clips the result to a signed OUT_W residual.
//             The result is presented on a valid/ready output.
//  Ports    : ap_clk, ap_rst_n (sync, active-low)
//             taps_i, shift_i      per-sample config, sampled on first beat
//             in_valid/in_ready/in_prod      product stream
//             out_valid/out_ready/out_data/out_sat   residual stream
//             sat_cnt              saturation count (IDCT2_MAC_SAT_CNT_EN only)
//  Config   : `define IDCT2_MAC_SAT_CNT_EN adds the sat_cnt port and counter
//  Revision : 1.0  initial release
// ============================================================================
module idct2_mac_round_clip #(
    parameter int PROD_W   = 32,
    parameter int ACC_W    = 40,
    parameter int OUT_W    = 16,
    parameter int MAX_TAPS = 32,
    parameter int CNT_W    = 6
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [CNT_W-1:0]  taps_i,
    input  logic [4:0]        shift_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat
`ifdef IDCT2_MAC_SAT_CNT_EN
    ,
    output logic [15:0]       sat_cnt
`endif
);

    localparam logic [4:0] C_SHIFT_MAX = 5'd20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_ROUND = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ACC_W-1:0]         r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         r_taps;
    logic [4:0]               r_shift;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic [OUT_W-1:0]         r_out_data;
    logic                     r_out_sat;

    logic                     w_hs_in;
    logic [CNT_W-1:0]         w_taps_sel;
    logic [4:0]               w_shift_sel;
    logic [ACC_W-1:0]         w_prod_ext;
    logic [ACC_W-1:0]         w_rnd;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_r;
    logic                     w_fits;
    logic [OUT_W-1:0]         w_clip;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

    assign w_hs_in     = in_valid & r_in_ready;
    assign w_taps_sel  = (taps_i == '0) ? CNT_W'(MAX_TAPS) : taps_i;
    assign w_shift_sel = (shift_i > C_SHIFT_MAX) ? C_SHIFT_MAX : shift_i;
    assign w_prod_ext  = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};

    // Round half up, then arithmetic shift in full accumulator width.
    assign w_rnd = (r_shift == 5'd0) ? '0 : (ACC_W'(1) << (r_shift - 5'd1));
    assign w_sum = r_acc + w_rnd;
    assign w_r   = w_sum >>> r_shift;

    // The value fits in OUT_W bits when every bit from the OUT_W sign bit upward
    // is identical. Otherwise, saturate toward the sign of the result.
    assign w_fits = (&w_r[ACC_W-1:OUT_W-1]) | ~(|w_r[ACC_W-1:OUT_W-1]);
    assign w_clip = w_fits      ? w_r[OUT_W-1:0] :
                    w_r[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                   {1'b0, {(OUT_W-1){1'b1}}};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs_in) begin
                    w_state_nxt = (w_taps_sel == CNT_W'(1)) ? S_ROUND : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_hs_in && ((r_cnt + CNT_W'(1)) == r_taps)) begin
                    w_state_nxt = S_ROUND;
                end
            end
            S_ROUND: w_state_nxt = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_taps      <= '0;
            r_shift     <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // The handshake flags are registered from the next state.
            // This makes them glitch-free and correct from the first cycle of each state.
            r_in_ready  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_ACCUM);
            r_out_valid <= (w_state_nxt == S_OUT);

            case (r_state)
                S_IDLE: begin
                    if (w_hs_in) begin
                        r_taps  <= w_taps_sel;
                        r_shift <= w_shift_sel;
                        r_acc   <= w_prod_ext;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                S_ACCUM: begin
                    if (w_hs_in) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ROUND: begin
                    r_out_data <= w_clip;
                    r_out_sat  <= ~w_fits;
                end
                default: ;
            endcase
        end
    end

`ifdef IDCT2_MAC_SAT_CNT_EN
    logic [15:0] r_sat_cnt;

    assign sat_cnt = r_sat_cnt;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_sat_cnt <= '0;
        end else if (r_out_valid && out_ready && r_out_sat && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_idct2_mac_round_clip.sv
`default_nettype none
// ============================================================================
//  Module   : tb_idct2_mac_round_clip
//  Purpose  : Self-checking bench for idct2_mac_round_clip. It uses directed
//             cases and randomized samples, and compares the DUT against an
//             arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_idct2_mac_round_clip;

    logic        ap_clk;
    logic        ap_rst_n;
    logic [5:0]  taps_i;
    logic [4:0]  shift_i;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_prod;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
`ifdef IDCT2_MAC_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    idct2_mac_round_clip dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .taps_i    (taps_i),
        .shift_i   (shift_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
`ifdef IDCT2_MAC_SAT_CNT_EN
        ,
        .sat_cnt   (sat_cnt)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int     n_chk  = 0;
    int     n_fail = 0;
    int     exp_sat_cnt = 0;
    longint q_prods[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: sum of all products, round half up, arithmetic shift, saturate.
    function automatic void model(input int sh_in, output logic [15:0] d, output logic s);
        longint sum = 0;
        longint rnd;
        longint r;
        int     sh;
        foreach (q_prods[i]) sum += q_prods[i];
        sh  = (sh_in > 20) ? 20 : sh_in;
        rnd = (sh == 0) ? 64'sd0 : (longint'(1) <<< (sh - 1));
        r   = (sum + rnd) >>> sh;
        if (r > 32767) begin
            d = 16'h7FFF; s = 1'b1;
        end else if (r < -32768) begin
            d = 16'h8000; s = 1'b1;
        end else begin
            d = 16'(r); s = 1'b0;
        end
    endfunction

    task automatic do_reset();
        ap_rst_n = 1'b0;
        @(posedge ap_clk); #1;
        exp_sat_cnt = 0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
`ifdef IDCT2_MAC_SAT_CNT_EN
        chk("rst_sat_cnt", sat_cnt, 0);
`endif
        ap_rst_n = 1'b1;
    endtask

    // Drive one beat and return after the edge that accepts it (+1 time unit).
    task automatic send_beat(input longint p, input bit gaps);
        bit acc;
        int t;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_valid = 1'b0;
                @(posedge ap_clk); #1;
            end
        end
        in_valid = 1'b1;
        in_prod  = 32'(p);
        t = 0;
        forever begin
            acc = in_ready;
            @(posedge ap_clk); #1;
            if (acc) break;
            t++;
            if (t > 100) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Full sample: beats from q_prods, latency check, optional backpressure, accept.
    task automatic run_sample(input int taps, input int shift, input int hold,
                              input bit gaps, input int mid_taps, input string nm);
        logic [15:0] ed;
        logic        es;
        model(shift, ed, es);
        taps_i  = 6'(taps);
        shift_i = 5'(shift);
        foreach (q_prods[i]) begin
            send_beat(q_prods[i], gaps);
            if (i == 0) begin
                taps_i  = 6'(mid_taps);
                shift_i = 5'($urandom_range(0, 31));
            end
        end
        chk({nm, "_round_valid"}, out_valid, 0);
        @(posedge ap_clk); #1;
        chk({nm, "_out_valid"}, out_valid, 1);
        chk({nm, "_data"}, out_data, ed);
        chk({nm, "_sat"}, out_sat, es);
        for (int h = 0; h < hold; h++) begin
            @(posedge ap_clk); #1;
            chk({nm, "_hold_valid"}, out_valid, 1);
            chk({nm, "_hold_data"}, out_data, ed);
            chk({nm, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        out_ready = 1'b0;
        if (es && exp_sat_cnt < 65535) exp_sat_cnt++;
        chk({nm, "_post_valid"}, out_valid, 0);
        chk({nm, "_post_in_ready"}, in_ready, 1);
`ifdef IDCT2_MAC_SAT_CNT_EN
        chk({nm, "_sat_cnt"}, sat_cnt, 64'(exp_sat_cnt));
`endif
    endtask

    task automatic fill_const(input int n, input longint v);
        q_prods.delete();
        for (int i = 0; i < n; i++) q_prods.push_back(v);
    endtask

    initial begin
        int     taps, n, sh;
        longint t2v[4];
        ap_rst_n  = 1'b1;
        taps_i    = '0;
        shift_i   = '0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;
        @(posedge ap_clk); #1;
        do_reset();
        @(posedge ap_clk); #1;

        // T1: basic rounding
        fill_const(4, 64);
        run_sample(4, 7, 0, 0, 9, "t1");

        // T2: rounding boundaries with a single tap
        t2v[0] = -64; t2v[1] = -65; t2v[2] = 63; t2v[3] = 64;
        for (int k = 0; k < 4; k++) begin
            fill_const(1, t2v[k]);
            run_sample(1, 7, 0, 0, 5, "t2");
        end

        // T3: positive and negative saturation
        fill_const(2, 64'sd2147483647);
        run_sample(2, 0, 0, 0, 2, "t3_pos");
        fill_const(2, -64'sd2147483648);
        run_sample(2, 0, 0, 0, 2, "t3_neg");

        // T4: backpressure hold
        fill_const(4, 64);
        run_sample(4, 7, 5, 0, 4, "t4");

        // T5: reset mid-sample discards the partial accumulation
        taps_i  = 6'd4;
        shift_i = 5'd0;
        send_beat(1000, 0);
        send_beat(1000, 0);
        do_reset();
        repeat (6) begin
            @(posedge ap_clk); #1;
            chk("t5_no_valid", out_valid, 0);
        end
        fill_const(4, 64);
        run_sample(4, 7, 0, 0, 4, "t5_after");

        // T6: taps_i==0 selects 32 taps; mid-sample taps change ignored
        fill_const(32, 1);
        run_sample(0, 0, 0, 1, 3, "t6");

        // Shift clamp: 25 behaves as 20
        fill_const(2, 64'sd1 <<< 24);
        run_sample(2, 25, 0, 0, 1, "clamp");

        // Randomized samples
        for (int s = 0; s < 40; s++) begin
            taps = $urandom_range(0, 32);
            n    = (taps == 0) ? 32 : taps;
            sh   = $urandom_range(0, 31);
            q_prods.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 0)
                    q_prods.push_back(longint'($urandom_range(0, 200000)) - 100000);
                else
                    q_prods.push_back(longint'(int'($urandom)));
            end
            run_sample(taps, sh, $urandom_range(0, 3), 1, $urandom_range(0, 63), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
